// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: registers the MEM slot, then
// extracts loads, selects the result and drives the register-file write port.
// Optional retire counter enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic        jump_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] mem_data_in,
  input  logic [31:0] pc_plus4_in,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        wb_fwd_valid,
  output logic        load_misaligned
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retired_cnt
`endif
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_to_reg;
    logic            jump;
    logic [2:0]      funct3;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] mdata;
    logic [XLEN-1:0] pc4;
  } wb_slot_t;

  wb_slot_t slot_d;
  wb_slot_t slot_q;

  always_comb begin
    slot_d            = '0;
    slot_d.valid      = valid_in;
    slot_d.reg_write  = reg_write_in;
    slot_d.mem_to_reg = mem_to_reg_in;
    slot_d.jump       = jump_in;
    slot_d.funct3     = funct3_in;
    slot_d.rd         = rd_in;
    slot_d.alu        = alu_result_in;
    slot_d.mdata      = mem_data_in;
    slot_d.pc4        = pc_plus4_in;
  end

  // Flush only kills the valid bit; the payload holds since it is don't-care.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (flush) begin
      slot_q.valid <= 1'b0;
    end else if (!stall) begin
      slot_q <= slot_d;
    end
  end

  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_val;
  logic            is_half;
  logic            is_byte;
  logic            misaligned_c;

  // Byte/halfword lane extraction and extension; unknown widths behave as LW.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = slot_q.alu[1] ? slot_q.mdata[31:16] : slot_q.mdata[15:0];
    load_val = slot_q.mdata;
    is_half  = 1'b0;
    is_byte  = 1'b0;
    case (slot_q.alu[1:0])
      2'd0:    byte_sel = slot_q.mdata[7:0];
      2'd1:    byte_sel = slot_q.mdata[15:8];
      2'd2:    byte_sel = slot_q.mdata[23:16];
      default: byte_sel = slot_q.mdata[31:24];
    endcase
    case (slot_q.funct3)
      F3_LB: begin
        load_val = {{24{byte_sel[7]}}, byte_sel};
        is_byte  = 1'b1;
      end
      F3_LBU: begin
        load_val = {24'h000000, byte_sel};
        is_byte  = 1'b1;
      end
      F3_LH: begin
        load_val = {{16{half_sel[15]}}, half_sel};
        is_half  = 1'b1;
      end
      F3_LHU: begin
        load_val = {16'h0000, half_sel};
        is_half  = 1'b1;
      end
      F3_LW:   load_val = slot_q.mdata;
      default: load_val = slot_q.mdata;
    endcase
  end

  // Natural alignment: halves need addr[0]==0, words need addr[1:0]==0.
  always_comb begin
    misaligned_c = 1'b0;
    if (slot_q.valid && slot_q.mem_to_reg) begin
      if (is_half) begin
        misaligned_c = slot_q.alu[0];
      end else if (!is_byte) begin
        misaligned_c = (slot_q.alu[1:0] != 2'b00);
      end
    end
  end

  always_comb begin
    load_misaligned = misaligned_c;
    rf_waddr        = slot_q.rd;
    rf_we           = slot_q.valid && slot_q.reg_write &&
                      (slot_q.rd != RW'(0)) && !misaligned_c;
    wb_fwd_valid    = rf_we;
    if (slot_q.jump) begin
      rf_wdata = slot_q.pc4;
    end else if (slot_q.mem_to_reg) begin
      rf_wdata = load_val;
    end else begin
      rf_wdata = slot_q.alu;
    end
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  // Counts slots leaving WB; bubbles have valid=0 and are not counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (slot_q.valid && !stall) begin
      retired_cnt <= retired_cnt + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed test-plan cases plus random
// traffic compared against a behavioural model of the writeback rules.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic        valid_in, reg_write_in, mem_to_reg_in, jump_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic [31:0] alu_result_in, mem_data_in, pc_plus4_in;
  logic        rf_we, wb_fwd_valid, load_misaligned;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .valid_in(valid_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .jump_in(jump_in),
    .funct3_in(funct3_in), .rd_in(rd_in), .alu_result_in(alu_result_in),
    .mem_data_in(mem_data_in), .pc_plus4_in(pc_plus4_in),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_fwd_valid(wb_fwd_valid), .load_misaligned(load_misaligned)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  // Model of the instruction currently sitting in WB.
  bit          m_valid, m_rw, m_mtr, m_jump;
  int unsigned m_f3, m_rd, m_alu, m_md, m_pc4, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned load_value(int unsigned f3, int unsigned addr, int unsigned md);
    int unsigned b, h;
    b = (md >> (8 * (addr % 4))) % 256;
    h = (md >> (16 * ((addr / 2) % 2))) % 65536;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      4: return b;
      1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      5: return h;
      default: return md;
    endcase
  endfunction

  function automatic bit misaligned();
    if (!(m_valid && m_mtr)) return 1'b0;
    if (m_f3 == 0 || m_f3 == 4) return 1'b0;
    if (m_f3 == 1 || m_f3 == 5) return (m_alu % 2) != 0;
    return (m_alu % 4) != 0;
  endfunction

  function automatic bit exp_we();
    return m_valid && m_rw && (m_rd != 0) && !misaligned();
  endfunction

  function automatic int unsigned exp_wdata();
    if (m_jump) return m_pc4;
    if (m_mtr)  return load_value(m_f3, m_alu, m_md);
    return m_alu;
  endfunction

  // Apply the clock-edge update rules to the model using the inputs now driven.
  task automatic model_edge();
    if (!rst_n) m_cnt = 0;
    else if (m_valid && !stall) m_cnt = m_cnt + 1;
    if (!rst_n) begin
      {m_valid, m_rw, m_mtr, m_jump} = '0;
      {m_f3, m_rd, m_alu, m_md, m_pc4} = '0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (!stall) begin
      m_valid = valid_in; m_rw = reg_write_in; m_mtr = mem_to_reg_in;
      m_jump = jump_in; m_f3 = funct3_in; m_rd = rd_in;
      m_alu = alu_result_in; m_md = mem_data_in; m_pc4 = pc_plus4_in;
    end
  endtask

  task automatic compare_model();
    check("rf_we", 32'(rf_we), 32'(exp_we()));
    check("rf_waddr", 32'(rf_waddr), m_rd);
    check("rf_wdata", rf_wdata, exp_wdata());
    check("wb_fwd_valid", 32'(wb_fwd_valid), 32'(exp_we()));
    check("load_misaligned", 32'(load_misaligned), 32'(misaligned()));
`ifdef MEM_WB_RETIRE_CNT_EN
    check("retired_cnt", retired_cnt, m_cnt);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic randomize_inputs();
    int unsigned sel;
    sel = $urandom_range(4);
    valid_in      = ($urandom_range(9) != 0);
    reg_write_in  = ($urandom_range(7) != 0);
    mem_to_reg_in = $urandom_range(1);
    jump_in       = ($urandom_range(5) == 0);
    funct3_in     = (sel == 0) ? 3'd0 : (sel == 1) ? 3'd1 : (sel == 2) ? 3'd2 :
                    (sel == 3) ? 3'd4 : 3'd5;
    rd_in         = 5'($urandom);
    alu_result_in = $urandom;
    mem_data_in   = $urandom;
    pc_plus4_in   = $urandom;
  endtask

  task automatic drive(input bit v, input bit rw, input bit mtr, input bit j,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] md, input logic [31:0] pc4);
    stall = 1'b0; flush = 1'b0;
    valid_in = v; reg_write_in = rw; mem_to_reg_in = mtr; jump_in = j;
    funct3_in = f3; rd_in = rd; alu_result_in = alu; mem_data_in = md; pc_plus4_in = pc4;
  endtask

  initial begin
    logic [31:0] ld_exp [5];
    logic [2:0]  ld_f3  [5];
    logic [31:0] ld_adr [5];
    ld_exp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8081, 32'h00008081, 32'h8081F27F};
    ld_f3  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    ld_adr = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};

    // Reset with random inputs.
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    randomize_inputs();
    for (int i = 0; i < 2; i++) begin
      step();
      randomize_inputs();
      stall = $urandom_range(1); flush = $urandom_range(1);
    end
    check("reset_we", 32'(rf_we), 32'd0);
    check("reset_wdata", rf_wdata, 32'd0);
    check("reset_waddr", 32'(rf_waddr), 32'd0);
    check("reset_fwd", 32'(wb_fwd_valid), 32'd0);
    check("reset_mis", 32'(load_misaligned), 32'd0);
`ifdef MEM_WB_RETIRE_CNT_EN
    check("reset_cnt", retired_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // Load extraction.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 0, ld_f3[i], 5'd3, ld_adr[i], 32'h8081_F27F, 32'h0);
      step();
      check($sformatf("load_%0d_wdata", i), rf_wdata, ld_exp[i]);
      check($sformatf("load_%0d_we", i), 32'(rf_we), 32'd1);
    end

    // Source select and x0.
    drive(1, 1, 0, 0, 3'd0, 5'd5, 32'h1234, 32'hDEAD_BEEF, 32'h0);
    step();
    check("alu_we", 32'(rf_we), 32'd1);
    check("alu_wdata", rf_wdata, 32'h1234);
    drive(1, 1, 0, 1, 3'd0, 5'd1, 32'h9999, 32'h0, 32'h40);
    step();
    check("jal_wdata", rf_wdata, 32'h40);
    drive(1, 1, 0, 0, 3'd0, 5'd0, 32'h1234, 32'h0, 32'h0);
    step();
    check("x0_we", 32'(rf_we), 32'd0);

    // Misalignment.
    drive(1, 1, 1, 0, 3'd2, 5'd7, 32'h102, 32'h1111_2222, 32'h0);
    step();
    check("lw_mis", 32'(load_misaligned), 32'd1);
    check("lw_mis_we", 32'(rf_we), 32'd0);
    drive(1, 1, 1, 0, 3'd1, 5'd7, 32'h101, 32'h1111_2222, 32'h0);
    step();
    check("lh_mis", 32'(load_misaligned), 32'd1);
    check("lh_mis_we", 32'(rf_we), 32'd0);
    drive(1, 1, 1, 0, 3'd0, 5'd7, 32'h101, 32'h1111_2222, 32'h0);
    step();
    check("lb_mis", 32'(load_misaligned), 32'd0);
    check("lb_mis_we", 32'(rf_we), 32'd1);

    // Stall holds instruction A while inputs change; then flush+stall.
    drive(1, 1, 0, 0, 3'd0, 5'd9, 32'hA5A5_0001, 32'h0, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      stall = 1'b1;
      step();
      check("stall_wdata", rf_wdata, 32'hA5A5_0001);
      check("stall_we", 32'(rf_we), 32'd1);
    end
    stall = 1'b1; flush = 1'b1;
    step();
    check("flush_stall_we", 32'(rf_we), 32'd0);

    // Reset asserted mid-stall.
    drive(1, 1, 0, 0, 3'd0, 5'd4, 32'h77, 32'h0, 32'h0);
    step();
    stall = 1'b1; rst_n = 1'b0;
    step();
    check("rst_stall_wdata", rf_wdata, 32'd0);
    rst_n = 1'b1;

    // Retire count: 4 instructions, 1 flush bubble, 2 stalled cycles.
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 3'd0, 5'(i + 1), 32'(i), 32'h0, 32'h0);
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0; stall = 1'b1;
    step();
    step();
`ifdef MEM_WB_RETIRE_CNT_EN
    check("retire_4", retired_cnt, 32'd4);
`endif
    stall = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(7) == 0);
      rst_n = ($urandom_range(49) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
